button_event_arbiter: RTL and testbench
=======================================

// Module: button_event_arbiter
// PURPOSE
// Turns the debounced button levels (five buttons on the Wordle board) into a
// single stream of one-shot key events for the game FSM. It generates the
// shared sample tick that paces every debouncer and the hold/auto-repeat timer.
// Simultaneous presses are queued and then granted one at a time by fixed priority.
// It sits between the debouncer bank and the game/letter-select logic.
// PARAMETERS
// N_BTN        5       number of button inputs (max 8)
// TICK_DIV     131072  clk_sys cycles per sample_tick (1 = tick every cycle)
// HOLD_TICKS   40      ticks a granted button must stay high before first repeat
// REPEAT_TICKS 10      ticks between successive repeats while still held
// PORTS
// clk_sys     in   1      system clock, the single clock domain
// rst         in   1      reset; asynchronous, active-high
// btn_level   in   N_BTN  debounced button levels, synchronous to clk_sys
// evt_ready   in   1      consumer accepts the event on a cycle with evt_valid=1
// sample_tick out  1      1-cycle strobe every TICK_DIV cycles, feeds debouncers
// evt_valid   out  1      event slot holds an unconsumed event
// evt_code    out  3      index of the button for this event
// evt_repeat  out  1      1 = auto-repeat event, 0 = fresh press
// overrun     out  1      1-cycle pulse: a press was lost because one was already pending
// BEHAVIOUR
// - Reset: prescaler=0, sample_tick=0, evt_valid=0, evt_code=0, evt_repeat=0,
//   overrun=0, pending=0, rpt_pending=0, hold FSM=IDLE, btn_prev=all ones.
//   btn_prev=all ones means a button held through reset gives no event.
// - Prescaler counts 0..TICK_DIV-1 and wraps. sample_tick=1 in the cycle the count is TICK_DIV-1.
// - Edge detect: rise[i] = btn_level[i] & ~btn_prev[i]; btn_prev updates every cycle.
// - rise[i] sets pending[i] at that clock edge.
// - If pending[i] is already set and not being granted that same cycle, the press is lost:
//   overrun pulses and pending[i] stays 1.
// - Grant: the slot is free when evt_valid=0 or (evt_valid & evt_ready).
//   In a free-slot cycle, the lowest-index pending bit loads into evt_code with evt_repeat=0.
//   That pending bit clears at the same edge. A same-cycle rise on that bit sets it again
//   (set wins), with no overrun.
// - If no press is pending and rpt_pending=1, the slot loads held_idx with evt_repeat=1
//   and rpt_pending clears. Fresh presses always beat repeats.
// - If nothing is pending and evt_ready=1, evt_valid falls. evt_code and evt_repeat hold
//   their values and stay stable while evt_valid=1 and evt_ready=0.
// - Latency: btn_level rises before edge k, pending is set at k, evt_valid=1 after k+1
//   (slot free, no higher-priority pending). Throughput is one event per cycle.
// - Hold FSM, one tracker for the most recently granted fresh press (held_idx, cnt):
//   IDLE   : grant of fresh press i -> HOLD, held_idx=i, cnt=0.
//   HOLD   : on sample_tick, cnt++. When cnt reaches HOLD_TICKS-1 on a tick:
//            rpt_pending=1, cnt=0, go to REPEAT.
//   REPEAT : on sample_tick, cnt++. When cnt reaches REPEAT_TICKS-1 on a tick:
//            rpt_pending=1, cnt=0.
//   In any non-IDLE state, btn_level[held_idx]=0 -> IDLE, cnt=0, rpt_pending=0.
//   A fresh grant of any other button restarts HOLD on that button (cnt=0) and clears
//   rpt_pending. A re-grant of held_idx also restarts HOLD.
// - A repeat that finds rpt_pending already set is merged. It is not an overrun.
// - cnt width is clog2(max(HOLD_TICKS,REPEAT_TICKS)). The prescaler width is clog2(TICK_DIV).
//   Both counters are unsigned and wrap only by explicit reset to 0.
// - rst asserted mid-operation clears everything immediately (asynchronous).
//   An event held in the slot is dropped.
// TESTING (bench parameters: TICK_DIV=4, HOLD_TICKS=3, REPEAT_TICKS=2)
// - Tick: after reset, sample_tick is high at cycles 3, 7, 11 and low at all others.
// - Single press: btn_level=00001 for 1 cycle, evt_ready=1 -> evt_valid for exactly 1
//   cycle, 2 edges after the rise, with code 0 and repeat 0.
// - Simultaneous: btn_level 00000->10100 at once, evt_ready=1 -> code 2, then code 4
//   on consecutive cycles, overrun=0.
// - Backpressure: evt_ready=0, press btn1, release, press again -> overrun pulses once.
//   Then evt_ready=1 -> exactly one code-1 event.
// - Auto-repeat: hold btn3 -> first event repeat=0, then repeat=1 event after 3 ticks,
//   then one every 2 ticks. Release -> no further events.
// - Reset mid-operation: rst pulses while evt_valid=1 and btn0 is still held.
//   evt_valid falls immediately, and no event appears until btn0 is released and re-pressed.

Source files
------------

// File: rtl/button_event_arbiter_if.sv
// Key-event interface between the button arbiter, its debouncer bank and the game FSM.
// The slave modport is the arbiter side; the master modport is the driver/consumer side.
interface button_event_arbiter_if #(
  parameter int N_BTN = 5
);
  logic [N_BTN-1:0] btn_level;
  logic             evt_ready;
  logic             sample_tick;
  logic             evt_valid;
  logic [2:0]       evt_code;
  logic             evt_repeat;
  logic             overrun;

  modport slave (
    input  btn_level, evt_ready,
    output sample_tick, evt_valid, evt_code, evt_repeat, overrun
  );

  modport master (
    output btn_level, evt_ready,
    input  sample_tick, evt_valid, evt_code, evt_repeat, overrun
  );
endinterface

// File: rtl/button_event_arbiter.sv
// Turns debounced button levels into a one-at-a-time stream of key events with
// fixed-priority grant, hold/auto-repeat, and the shared debouncer sample tick.
module button_event_arbiter #(
  parameter int N_BTN        = 5,
  parameter int TICK_DIV     = 131072,
  parameter int HOLD_TICKS   = 40,
  parameter int REPEAT_TICKS = 10
) (
  input logic                    clk_sys,
  input logic                    rst,
  button_event_arbiter_if.slave  bus
);

  localparam int PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CMAX = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  localparam logic [PW-1:0] PRESC_LAST  = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_TICKS - 1);
  localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_TICKS - 1);

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_REPEAT} state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [N_BTN-1:0] btn_prev_q, btn_prev_d;
  logic [N_BTN-1:0] pending_q, pending_d;
  logic             evt_valid_q, evt_valid_d;
  logic [2:0]       evt_code_q, evt_code_d;
  logic             evt_repeat_q, evt_repeat_d;
  logic             overrun_q, overrun_d;
  logic             rpt_pending_q, rpt_pending_d;
  logic [2:0]       held_idx_q, held_idx_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             sample_tick;
  logic [N_BTN-1:0] rise;
  logic [N_BTN-1:0] grant_oh;
  logic [2:0]       grant_idx;
  logic             slot_free, fresh_grant, rpt_grant, rpt_set, rpt_clear;

  // NOTE: every signal assigned in this block gets a default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    sample_tick = (presc_q == PRESC_LAST);
    presc_d     = sample_tick ? '0 : presc_q + 1'b1;

    rise       = bus.btn_level & ~btn_prev_q;
    btn_prev_d = bus.btn_level;

    // Lowest index wins: scan downwards so the last hit is the smallest index.
    grant_idx = '0;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (pending_q[i]) grant_idx = i[2:0];
    end

    slot_free   = !evt_valid_q || bus.evt_ready;
    fresh_grant = slot_free && (|pending_q);
    rpt_grant   = slot_free && !(|pending_q) && rpt_pending_q;
    grant_oh    = fresh_grant ? (N_BTN'(1) << grant_idx) : '0;

    pending_d = (pending_q & ~grant_oh) | rise;
    overrun_d = |(rise & pending_q & ~grant_oh);

    evt_valid_d  = evt_valid_q;
    evt_code_d   = evt_code_q;
    evt_repeat_d = evt_repeat_q;
    if (fresh_grant) begin
      evt_valid_d  = 1'b1;
      evt_code_d   = grant_idx;
      evt_repeat_d = 1'b0;
    end else if (rpt_grant) begin
      evt_valid_d  = 1'b1;
      evt_code_d   = held_idx_q;
      evt_repeat_d = 1'b1;
    end else if (slot_free) begin
      evt_valid_d  = 1'b0;
    end

    state_d    = state_q;
    held_idx_d = held_idx_q;
    cnt_d      = cnt_q;
    rpt_set    = 1'b0;
    rpt_clear  = 1'b0;
    case (state_q)
      S_HOLD: if (sample_tick) begin
        if (cnt_q == HOLD_LAST) begin
          rpt_set = 1'b1;
          cnt_d   = '0;
          state_d = S_REPEAT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_REPEAT: if (sample_tick) begin
        if (cnt_q == REPEAT_LAST) begin
          rpt_set = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase

    if (state_q != S_IDLE && !bus.btn_level[held_idx_q]) begin
      state_d   = S_IDLE;
      cnt_d     = '0;
      rpt_clear = 1'b1;
    end

    // A new fresh press always retargets the tracker, even over a release.
    if (fresh_grant) begin
      state_d    = S_HOLD;
      held_idx_d = grant_idx;
      cnt_d      = '0;
      rpt_clear  = 1'b1;
    end

    rpt_pending_d = rpt_clear ? 1'b0 : ((rpt_pending_q & ~rpt_grant) | rpt_set);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      presc_q       <= '0;
      btn_prev_q    <= '1;
      pending_q     <= '0;
      evt_valid_q   <= 1'b0;
      evt_code_q    <= '0;
      evt_repeat_q  <= 1'b0;
      overrun_q     <= 1'b0;
      rpt_pending_q <= 1'b0;
      held_idx_q    <= '0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      presc_q       <= presc_d;
      btn_prev_q    <= btn_prev_d;
      pending_q     <= pending_d;
      evt_valid_q   <= evt_valid_d;
      evt_code_q    <= evt_code_d;
      evt_repeat_q  <= evt_repeat_d;
      overrun_q     <= overrun_d;
      rpt_pending_q <= rpt_pending_d;
      held_idx_q    <= held_idx_d;
      cnt_q         <= cnt_d;
    end
  end

  assign bus.sample_tick = sample_tick;
  assign bus.evt_valid   = evt_valid_q;
  assign bus.evt_code    = evt_code_q;
  assign bus.evt_repeat  = evt_repeat_q;
  assign bus.overrun     = overrun_q;

endmodule

// File: tb/tb_button_event_arbiter.sv
// Directed bench for button_event_arbiter: vector table for single, simultaneous and
// backpressured presses, plus sequences for tick timing, auto-repeat and mid-run reset.
module tb_button_event_arbiter;

  logic clk_sys = 1'b0;
  logic rst     = 1'b1;

  button_event_arbiter_if #(.N_BTN(5)) bus();

  button_event_arbiter #(
    .N_BTN(5), .TICK_DIV(4), .HOLD_TICKS(3), .REPEAT_TICKS(2)
  ) dut (
    .clk_sys (clk_sys),
    .rst     (rst),
    .bus     (bus.slave)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic [4:0] btn;
    logic       rdy;
    logic       valid;
    logic [2:0] code;
    logic       rep;
    logic       ov;
  } vec_t;

  vec_t vecs [18];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  initial begin
    int ticks, nrep, nevt;
    logic seen_fresh;

    vecs[0]  = '{5'b00001, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0};
    vecs[1]  = '{5'b00000, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0};
    vecs[2]  = '{5'b00000, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0};
    vecs[3]  = '{5'b00000, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0};
    vecs[4]  = '{5'b10100, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0};
    vecs[5]  = '{5'b10100, 1'b1, 1'b1, 3'd2, 1'b0, 1'b0};
    vecs[6]  = '{5'b10100, 1'b1, 1'b1, 3'd4, 1'b0, 1'b0};
    vecs[7]  = '{5'b00000, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0};
    vecs[8]  = '{5'b00000, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0};
    vecs[9]  = '{5'b00001, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};
    vecs[10] = '{5'b00000, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0};
    vecs[11] = '{5'b00010, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0};
    vecs[12] = '{5'b00000, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0};
    vecs[13] = '{5'b00010, 1'b0, 1'b1, 3'd0, 1'b0, 1'b1};
    vecs[14] = '{5'b00000, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0};
    vecs[15] = '{5'b00000, 1'b1, 1'b1, 3'd1, 1'b0, 1'b0};
    vecs[16] = '{5'b00000, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0};
    vecs[17] = '{5'b00000, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0};

    bus.btn_level = '0;
    bus.evt_ready = 1'b1;

    // Reset values, then release reset away from the clock edge.
    step();
    step();
    check("rst_valid",   bus.evt_valid,   0);
    check("rst_code",    bus.evt_code,    0);
    check("rst_repeat",  bus.evt_repeat,  0);
    check("rst_overrun", bus.overrun,     0);
    check("rst_tick",    bus.sample_tick, 0);
    rst = 1'b0;

    // Cycle 0 is the first cycle after release; ticks land on 3, 7, 11.
    check("tick_c0", bus.sample_tick, 0);
    for (int c = 1; c < 12; c++) begin
      step();
      check($sformatf("tick_c%0d", c), bus.sample_tick, (c % 4 == 3) ? 1 : 0);
    end

    for (int i = 0; i < 18; i++) begin
      bus.btn_level = vecs[i].btn;
      bus.evt_ready = vecs[i].rdy;
      step();
      check($sformatf("v%0d_valid", i), bus.evt_valid, vecs[i].valid);
      check($sformatf("v%0d_overrun", i), bus.overrun, vecs[i].ov);
      if (vecs[i].valid) begin
        check($sformatf("v%0d_code", i), bus.evt_code, vecs[i].code);
        check($sformatf("v%0d_repeat", i), bus.evt_repeat, vecs[i].rep);
      end
    end

    // Auto-repeat on btn3: first repeat 3 ticks after the press, then every 2 ticks.
    bus.evt_ready = 1'b1;
    bus.btn_level = 5'b01000;
    ticks = 0;
    nrep = 0;
    seen_fresh = 1'b0;
    for (int c = 0; c < 200 && nrep < 3; c++) begin
      step();
      if (bus.evt_valid) begin
        check("ar_code", bus.evt_code, 3);
        if (!seen_fresh) begin
          check("ar_fresh_repeat", bus.evt_repeat, 0);
          seen_fresh = 1'b1;
        end else begin
          check("ar_repeat_flag", bus.evt_repeat, 1);
          check($sformatf("ar_ticks_%0d", nrep), ticks, (nrep == 0) ? 3 : 2);
          nrep++;
        end
        ticks = 0;
      end
      if (bus.sample_tick) ticks++;
    end
    check("ar_repeat_count", nrep, 3);
    bus.btn_level = '0;
    nevt = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (bus.evt_valid) nevt++;
    end
    check("ar_after_release", nevt, 0);

    // Reset while an event sits in the slot and btn0 stays held.
    bus.evt_ready = 1'b0;
    bus.btn_level = 5'b00001;
    step();
    step();
    check("mr_pre_valid", bus.evt_valid, 1);
    check("mr_pre_code",  bus.evt_code,  0);
    #2;
    rst = 1'b1;
    #1;
    check("mr_async_valid", bus.evt_valid, 0);
    step();
    rst = 1'b0;
    bus.evt_ready = 1'b1;
    nevt = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (bus.evt_valid) nevt++;
    end
    check("mr_held_no_event", nevt, 0);
    bus.btn_level = '0;
    step();
    step();
    bus.btn_level = 5'b00001;
    step();
    check("mr_repress_pending", bus.evt_valid, 0);
    step();
    check("mr_repress_valid",  bus.evt_valid,  1);
    check("mr_repress_code",   bus.evt_code,   0);
    check("mr_repress_repeat", bus.evt_repeat, 0);
    bus.btn_level = '0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
